apb_req_arbiter: RTL and testbench
==================================

# apb_req_arbiter

Round-robin arbiter and transfer sequencer that lets up to NUM_REQ local requesters share one APB master port. It sits between the bridge's internal request sources and the APB master interface signals (sel, enable, write, addr, wdata / ready, slverr, rdata). It drives the SETUP/ACCESS protocol itself, returns per-requester completion and status, and aborts transfers whose completer never asserts ready.

## Interface

- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, APB data width
- TIMEOUT, 16, max ACCESS cycles before abort; 0 disables the timeout

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request level; held until matching req_done
- req_wr  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  flat; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  flat; same packing
- req_done  out  NUM_REQ  one-cycle completion pulse, one-hot
- req_err  out  1  status, valid with req_done: slverr or timeout
- req_rdata  out  DATA_WIDTH  read data, valid with req_done on reads
- busy  out  1  transfer in progress (SETUP or ACCESS)
- grant_id  out  $clog2(NUM_REQ)  index of current or last granted requester
- sel, enable, write  out  1  APB control
- addr  out  ADDR_WIDTH  APB address
- wdata  out  DATA_WIDTH  APB write data
- ready, slverr  in  1  APB completer response
- rdata  in  DATA_WIDTH  APB read data

## Operation

- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: eligible = req_valid & ~req_done.
  - Masking the requester currently pulsing done prevents a re-grant of a finished request.
  - If eligible != 0, pick the first set bit searching from last_grant+1 upward, with wrap-around.
  - Latch that requester's wr/addr/wdata into write/addr/wdata, set grant_id and last_grant, then go to SETUP.
- SETUP: sel=1, enable=0. Always go to ACCESS next.
- ACCESS: sel=1, enable=1. addr, write and wdata are stable throughout.
  - ready=1: go to IDLE. Next cycle: sel=enable=0, req_done[grant_id]=1, req_err=slverr.
    - On a read with slverr=0, req_rdata=rdata.
    - On a read with slverr=1, req_rdata=0.
    - On a write, req_rdata holds its previous value.
  - ready=0 and TIMEOUT!=0 and wait counter = TIMEOUT-1: abort to IDLE. Next cycle: sel=enable=0, req_done[grant_id]=1, req_err=1; req_rdata=0 on reads.
  - Wait counter clears on entry to SETUP and increments on each ACCESS cycle with ready=0.
- addr, wdata and write hold their last values between transfers.
- req_err is 0 whenever no req_done bit is set.
- busy = (state != IDLE).
- Requester contract: hold req_valid and its operands stable from assertion until req_done. Deassert req_valid (or present the next request) in the req_done cycle.
- A requester dropping req_valid before grant is simply not granted. Dropping it after grant has no effect on the transfer in flight.

## Timing

- Reset values: state=IDLE; sel, enable, write, busy, req_done, req_err = 0; addr, wdata, req_rdata, grant_id = 0; last_grant = NUM_REQ-1, so requester 0 wins first; wait counter = 0.
- Reset mid-transfer: sel and enable are 0 at the next edge. No req_done pulse for the aborted transfer.
- Minimum transfer is 3 cycles per grant:
  - cycle 0: IDLE decision
  - cycle 1: SETUP
  - cycle 2: ACCESS with ready=1
  - cycle 3: done; this cycle is also the next IDLE decision
- Back-to-back throughput is one transfer per 3 cycles, plus one cycle per wait state.
- A timed-out transfer occupies exactly TIMEOUT ACCESS cycles.
- Simultaneous requests: exactly one grant per IDLE decision. The round-robin pointer advances only on grant.

## Test plan

- Single write: req0 write addr 0x10, wdata 0xDEADBEEF, ready tied 1 -> sel rises at cycle 1, enable at cycle 2 with addr=0x10, wdata=0xDEADBEEF, write=1; req_done=4'b0001 and req_err=0 at cycle 3.
- Read with 2 wait states: req2 read addr 0x20, ready low for 2 ACCESS cycles, rdata=0x12345678 -> 3 ACCESS cycles; req_done=4'b0100, req_rdata=0x12345678, req_err=0.
- Fairness: all four req_valid held high, each dropping after its done, ready=1 -> grant_id sequence 0,1,2,3, one done every 3 cycles. Re-raising req0 and req3 after the round -> order 0 then 3.
- Slave error: req1 read, ready=1 with slverr=1 -> req_done=4'b0010, req_err=1, req_rdata=0.
- Timeout: TIMEOUT=4, req3 write, ready stuck 0 -> exactly 4 ACCESS cycles, then sel=enable=0 with req_done=4'b1000 and req_err=1. The next request proceeds normally.
- Reset mid-ACCESS: rst=1 for 1 cycle during req1 ACCESS -> sel=enable=0 and req_done=0 at the next edge. With req0 and req1 then both valid, req0 is granted first.

Source files
------------

// File: rtl/apb_req_arbiter_if.sv
// apb_req_arbiter_if
// Groups the requester-side and APB-side signals of apb_req_arbiter.
//   Requester side : req_valid, req_wr, req_addr, req_wdata  (to arbiter)
//                    req_done, req_err, req_rdata, busy, grant_id (from arbiter)
//   APB side       : sel, enable, write, addr, wdata           (from arbiter)
//                    ready, slverr, rdata                       (to arbiter)
// Modports:
//   master : the arbiter itself (it is the APB master)
//   slave  : the environment (requesters plus APB completer)
//
// Handshake semantics: a requester raises req_valid with stable operands and
// holds them until it sees its req_done bit; the arbiter drives the APB
// SETUP (sel=1, enable=0) then ACCESS (sel=1, enable=1) phases, and a
// transfer completes on the first ACCESS cycle with ready=1 or is aborted
// after the configured number of ACCESS wait cycles.
interface apb_req_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Requester side
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_wr;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_done;
  logic                          req_err;
  logic [DATA_WIDTH-1:0]         req_rdata;
  logic                          busy;
  logic [GW-1:0]                 grant_id;

  // APB side
  logic                          sel;
  logic                          enable;
  logic                          write;
  logic [ADDR_WIDTH-1:0]         addr;
  logic [DATA_WIDTH-1:0]         wdata;
  logic                          ready;
  logic                          slverr;
  logic [DATA_WIDTH-1:0]         rdata;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, ready, slverr, rdata,
    output req_done, req_err, req_rdata, busy, grant_id,
           sel, enable, write, addr, wdata
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, ready, slverr, rdata,
    input  req_done, req_err, req_rdata, busy, grant_id,
           sel, enable, write, addr, wdata
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
// Round-robin arbiter and APB transfer sequencer: up to NUM_REQ local
// requesters share one APB master port. The block picks one requester per
// IDLE decision, runs SETUP/ACCESS, returns a one-hot completion pulse with
// status and read data, and aborts transfers whose completer never answers.
// Ports:
//   clk         : clock, all logic on the rising edge
//   rst         : synchronous active-high reset
//   bus         : apb_req_arbiter_if.master (requester + APB signals)
//   o_dbg_state : current FSM state (0 IDLE, 1 SETUP, 2 ACCESS)
// All outputs are registered.
module apb_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  apb_req_arbiter_if.master        bus,
  output logic [1:0]               o_dbg_state
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // The counter only needs to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                r_state,      w_state;
  logic                  r_sel,        w_sel;
  logic                  r_enable,     w_enable;
  logic                  r_write,      w_write;
  logic [ADDR_WIDTH-1:0] r_addr,       w_addr;
  logic [DATA_WIDTH-1:0] r_wdata,      w_wdata;
  logic [NUM_REQ-1:0]    r_req_done,   w_req_done;
  logic                  r_req_err,    w_req_err;
  logic [DATA_WIDTH-1:0] r_req_rdata,  w_req_rdata;
  logic                  r_busy,       w_busy;
  logic [GW-1:0]         r_grant_id,   w_grant_id;
  logic [GW-1:0]         r_last_grant, w_last_grant;
  logic [CW-1:0]         r_wait_cnt,   w_wait_cnt;

  logic [NUM_REQ-1:0]    w_eligible;
  logic                  w_hi_found, w_lo_found, w_found;
  logic [GW-1:0]         w_hi_pick,  w_lo_pick,  w_pick;
  logic                  w_timeout_hit;

  // Round-robin pick: the lowest eligible index above last_grant wins; if
  // there is none, wrap to the lowest eligible index at or below it. The
  // descending scan leaves the lowest index of each region in its pick.
  // The requester pulsing done this cycle is masked so a finished request
  // that has not yet dropped req_valid is not granted again.
  always_comb begin
    w_eligible = bus.req_valid & ~r_req_done;
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_pick  = '0;
    w_lo_pick  = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_eligible[j]) begin
        if (GW'(j) > r_last_grant) begin
          w_hi_found = 1'b1;
          w_hi_pick  = GW'(j);
        end else begin
          w_lo_found = 1'b1;
          w_lo_pick  = GW'(j);
        end
      end
    end
    w_found = w_hi_found | w_lo_found;
    w_pick  = w_hi_found ? w_hi_pick : w_lo_pick;
  end

  assign w_timeout_hit = (TIMEOUT != 0) && (r_wait_cnt == CW'(TIMEOUT - 1));

  // Next-state and next-output logic. Operand registers (write/addr/wdata)
  // and req_rdata hold by default so they keep their last values between
  // transfers.
  always_comb begin
    w_state      = r_state;
    w_sel        = r_sel;
    w_enable     = r_enable;
    w_write      = r_write;
    w_addr       = r_addr;
    w_wdata      = r_wdata;
    w_req_done   = '0;
    w_req_err    = 1'b0;
    w_req_rdata  = r_req_rdata;
    w_grant_id   = r_grant_id;
    w_last_grant = r_last_grant;
    w_wait_cnt   = r_wait_cnt;

    case (r_state)
      ST_IDLE: begin
        w_sel    = 1'b0;
        w_enable = 1'b0;
        if (w_found) begin
          w_state      = ST_SETUP;
          w_sel        = 1'b1;
          w_write      = bus.req_wr[w_pick];
          w_addr       = bus.req_addr[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
          w_wdata      = bus.req_wdata[w_pick*DATA_WIDTH +: DATA_WIDTH];
          w_grant_id   = w_pick;
          w_last_grant = w_pick;
          w_wait_cnt   = '0;
        end
      end

      ST_SETUP: begin
        w_state  = ST_ACCESS;
        w_sel    = 1'b1;
        w_enable = 1'b1;
      end

      ST_ACCESS: begin
        if (bus.ready) begin
          w_state                = ST_IDLE;
          w_sel                  = 1'b0;
          w_enable               = 1'b0;
          w_req_done[r_grant_id] = 1'b1;
          w_req_err              = bus.slverr;
          if (!r_write) begin
            // Errored reads return zero rather than whatever the bus carried.
            w_req_rdata = bus.slverr ? '0 : bus.rdata;
          end
        end else if (w_timeout_hit) begin
          w_state                = ST_IDLE;
          w_sel                  = 1'b0;
          w_enable               = 1'b0;
          w_req_done[r_grant_id] = 1'b1;
          w_req_err              = 1'b1;
          if (!r_write) begin
            w_req_rdata = '0;
          end
        end else if (TIMEOUT != 0) begin
          w_wait_cnt = r_wait_cnt + CW'(1);
        end
      end

      default: begin
        w_state  = ST_IDLE;
        w_sel    = 1'b0;
        w_enable = 1'b0;
      end
    endcase

    w_busy = (w_state != ST_IDLE);
  end

  // State register. last_grant resets to NUM_REQ-1 so requester 0 wins the
  // first decision after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sel        <= 1'b0;
      r_enable     <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_req_done   <= '0;
      r_req_err    <= 1'b0;
      r_req_rdata  <= '0;
      r_busy       <= 1'b0;
      r_grant_id   <= '0;
      r_last_grant <= GW'(NUM_REQ - 1);
      r_wait_cnt   <= '0;
    end else begin
      r_state      <= w_state;
      r_sel        <= w_sel;
      r_enable     <= w_enable;
      r_write      <= w_write;
      r_addr       <= w_addr;
      r_wdata      <= w_wdata;
      r_req_done   <= w_req_done;
      r_req_err    <= w_req_err;
      r_req_rdata  <= w_req_rdata;
      r_busy       <= w_busy;
      r_grant_id   <= w_grant_id;
      r_last_grant <= w_last_grant;
      r_wait_cnt   <= w_wait_cnt;
    end
  end

  assign bus.sel       = r_sel;
  assign bus.enable    = r_enable;
  assign bus.write     = r_write;
  assign bus.addr      = r_addr;
  assign bus.wdata     = r_wdata;
  assign bus.req_done  = r_req_done;
  assign bus.req_err   = r_req_err;
  assign bus.req_rdata = r_req_rdata;
  assign bus.busy      = r_busy;
  assign bus.grant_id  = r_grant_id;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter (NUM_REQ=4, 32-bit bus, TIMEOUT=4).
// Inputs change 1 time unit after a rising edge; outputs are observed at
// the same point, i.e. the value each register holds for that cycle.
module tb_apb_req_arbiter;
  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  int n_pass;
  int n_total;

  apb_req_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  apb_req_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .o_dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_if.req_wr[idx]            = wr;
    bus_if.req_addr[idx*AW +: AW] = a;
    bus_if.req_wdata[idx*DW +: DW] = d;
    bus_if.req_valid[idx]         = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    bus_if.req_valid = '0;
    bus_if.req_wr    = '0;
    bus_if.req_addr  = '0;
    bus_if.req_wdata = '0;
    bus_if.ready     = 1'b1;
    bus_if.slverr    = 1'b0;
    bus_if.rdata     = '0;

    // ---------------- reset state
    repeat (3) step();
    chk("rst_sel",      bus_if.sel,       0);
    chk("rst_enable",   bus_if.enable,    0);
    chk("rst_busy",     bus_if.busy,      0);
    chk("rst_done",     bus_if.req_done,  0);
    chk("rst_err",      bus_if.req_err,   0);
    chk("rst_grant",    bus_if.grant_id,  0);
    chk("rst_addr",     bus_if.addr,      0);
    chk("rst_rdata",    bus_if.req_rdata, 0);
    chk("rst_state",    dbg_state,        0);
    rst = 1'b0;

    // ---------------- fairness: all four request, order 0,1,2,3
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 32'h100 + 32'(i*4), 32'hA0 + 32'(i));
    for (int g = 0; g < NR; g++) begin
      step();  // SETUP
      chk("fair_grant",  bus_if.grant_id, g);
      chk("fair_setup",  {bus_if.sel, bus_if.enable}, 2'b10);
      chk("fair_addr",   bus_if.addr, 32'h100 + 32'(g*4));
      step();  // ACCESS, ready=1
      chk("fair_access", {bus_if.sel, bus_if.enable}, 2'b11);
      step();  // done
      chk("fair_done",   bus_if.req_done, 4'b0001 << g);
      chk("fair_err",    bus_if.req_err, 0);
      bus_if.req_valid[g] = 1'b0;
    end
    step();
    chk("fair_idle_busy", bus_if.busy, 0);
    chk("fair_idle_done", bus_if.req_done, 0);

    // re-raise 0 and 3: pointer sits at 3, so 0 first then 3
    bus_if.req_valid[0] = 1'b1;
    bus_if.req_valid[3] = 1'b1;
    step();
    chk("rr2_grant0", bus_if.grant_id, 0);
    step(); step();
    chk("rr2_done0", bus_if.req_done, 4'b0001);
    bus_if.req_valid[0] = 1'b0;
    step();
    chk("rr2_grant3", bus_if.grant_id, 3);
    step(); step();
    chk("rr2_done3", bus_if.req_done, 4'b1000);
    bus_if.req_valid[3] = 1'b0;

    // ---------------- single write on req0
    set_req(0, 1'b1, 32'h10, 32'hDEADBEEF);
    step();
    chk("wr_c1_sel",   {bus_if.sel, bus_if.enable}, 2'b10);
    chk("wr_c1_busy",  bus_if.busy, 1);
    chk("wr_c1_state", dbg_state, 1);
    step();
    chk("wr_c2_en",    {bus_if.sel, bus_if.enable}, 2'b11);
    chk("wr_c2_addr",  bus_if.addr, 32'h10);
    chk("wr_c2_wdata", bus_if.wdata, 32'hDEADBEEF);
    chk("wr_c2_write", bus_if.write, 1);
    chk("wr_c2_state", dbg_state, 2);
    step();
    chk("wr_c3_done",  bus_if.req_done, 4'b0001);
    chk("wr_c3_err",   bus_if.req_err, 0);
    chk("wr_c3_sel",   {bus_if.sel, bus_if.enable}, 2'b00);
    bus_if.req_valid[0] = 1'b0;

    // ---------------- read with 2 wait states on req2
    bus_if.ready = 1'b0;
    bus_if.rdata = 32'h12345678;
    set_req(2, 1'b0, 32'h20, 32'h0);
    step();
    chk("rd_grant", bus_if.grant_id, 2);
    chk("rd_write", bus_if.write, 0);
    chk("rd_addr",  bus_if.addr, 32'h20);
    step();
    chk("rd_acc1", {bus_if.sel, bus_if.enable}, 2'b11);
    step();
    chk("rd_acc2", {bus_if.sel, bus_if.enable}, 2'b11);
    chk("rd_acc2_done", bus_if.req_done, 0);
    step();
    chk("rd_acc3", {bus_if.sel, bus_if.enable}, 2'b11);
    bus_if.ready = 1'b1;
    step();
    chk("rd_done",  bus_if.req_done, 4'b0100);
    chk("rd_rdata", bus_if.req_rdata, 32'h12345678);
    chk("rd_err",   bus_if.req_err, 0);
    bus_if.req_valid[2] = 1'b0;

    // ---------------- slave error on req1 read
    bus_if.slverr = 1'b1;
    bus_if.rdata  = 32'hAAAA5555;
    set_req(1, 1'b0, 32'h30, 32'h0);
    step();
    chk("se_grant", bus_if.grant_id, 1);
    step(); step();
    chk("se_done",  bus_if.req_done, 4'b0010);
    chk("se_err",   bus_if.req_err, 1);
    chk("se_rdata", bus_if.req_rdata, 0);
    bus_if.req_valid[1] = 1'b0;
    bus_if.slverr = 1'b0;
    step();
    chk("se_err_clear", bus_if.req_err, 0);

    // ---------------- timeout on req3 write, ready stuck low
    bus_if.ready = 1'b0;
    set_req(3, 1'b1, 32'h50, 32'h000055AA);
    step();
    chk("to_grant", bus_if.grant_id, 3);
    for (int k = 0; k < TO; k++) begin
      step();
      chk("to_access", {bus_if.sel, bus_if.enable}, 2'b11);
      chk("to_nodone", bus_if.req_done, 0);
    end
    step();
    chk("to_sel",   {bus_if.sel, bus_if.enable}, 2'b00);
    chk("to_done",  bus_if.req_done, 4'b1000);
    chk("to_err",   bus_if.req_err, 1);
    chk("to_addr_hold", bus_if.addr, 32'h50);
    bus_if.req_valid[3] = 1'b0;
    bus_if.ready = 1'b1;

    // next request proceeds normally: req0 read
    bus_if.rdata = 32'hCAFEF00D;
    set_req(0, 1'b0, 32'h40, 32'h0);
    step();
    chk("nx_grant", bus_if.grant_id, 0);
    step(); step();
    chk("nx_done",  bus_if.req_done, 4'b0001);
    chk("nx_err",   bus_if.req_err, 0);
    chk("nx_rdata", bus_if.req_rdata, 32'hCAFEF00D);
    bus_if.req_valid[0] = 1'b0;

    // write keeps req_rdata
    bus_if.rdata = 32'h0BADF00D;
    set_req(2, 1'b1, 32'h60, 32'h00000001);
    step();
    chk("wh_grant", bus_if.grant_id, 2);
    step(); step();
    chk("wh_done",  bus_if.req_done, 4'b0100);
    chk("wh_rdata_hold", bus_if.req_rdata, 32'hCAFEF00D);
    bus_if.req_valid[2] = 1'b0;

    // ---------------- reset mid-ACCESS on req1
    bus_if.ready = 1'b0;
    set_req(1, 1'b0, 32'h70, 32'h0);
    step();
    chk("ra_grant", bus_if.grant_id, 1);
    step();
    chk("ra_access", {bus_if.sel, bus_if.enable}, 2'b11);
    rst = 1'b1;
    step();
    chk("ra_sel",  {bus_if.sel, bus_if.enable}, 2'b00);
    chk("ra_done", bus_if.req_done, 0);
    chk("ra_busy", bus_if.busy, 0);
    rst = 1'b0;
    bus_if.ready = 1'b1;
    set_req(0, 1'b1, 32'h80, 32'h00000080);
    step();
    chk("ra_grant0", bus_if.grant_id, 0);
    chk("ra_nodone", bus_if.req_done, 0);
    step(); step();
    chk("ra_done0", bus_if.req_done, 4'b0001);
    bus_if.req_valid[0] = 1'b0;
    step();
    chk("ra_grant1", bus_if.grant_id, 1);
    step(); step();
    chk("ra_done1", bus_if.req_done, 4'b0010);
    bus_if.req_valid[1] = 1'b0;

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
